cv32e40x_rvfi_trace_sequencer: RTL and testbench
================================================

# cv32e40x_rvfi_trace_sequencer

Synthesizable sequencer that sits between the core's RVFI retirement port and a trace sink such as a trace encoder, log writer or debug trace buffer. It captures each retired instruction into a small FIFO. It then unrolls that instruction into one trace beat per active memory slot, or a single beat if the instruction has no memory access, and delivers the beats over a valid/ready handshake. Back-pressure is absorbed by the FIFO; overflow is reported with a sticky flag and a drop counter.

## Interface
- NMEM, 2: number of RVFI memory slots per retired instruction (1..8).
- DEPTH, 4: FIFO depth in retired instructions; a power of two, at least 2.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- trace_en  in  1  capture enable; when 0, retirements are ignored and are not counted as drops.
- rvfi_valid  in  1  an instruction retires this cycle.
- rvfi_pc_rdata  in  32  PC of the retired instruction.
- rvfi_rd_addr / rvfi_rd_wdata  in  5/32  destination register address and write data.
- rvfi_mem_addr  in  32*NMEM  memory address per slot.
- rvfi_mem_rmask  in  4*NMEM  read byte mask per slot.
- rvfi_mem_wmask  in  4*NMEM  write byte mask per slot.
- rvfi_mem_rdata  in  32*NMEM  read data per slot.
- rvfi_mem_wdata  in  32*NMEM  write data per slot.
- trace_valid  out  1  a beat is presented.
- trace_ready  in  1  sink accepts the beat.
- trace_pc, trace_rd_addr, trace_rd_wdata  out  32/5/32  copied from the FIFO head entry.
- trace_memidx  out  $clog2(NMEM) (minimum 1)  slot index of the current beat.
- trace_mem_addr, trace_mem_rmask, trace_mem_rdata, trace_mem_wmask, trace_mem_wdata  out  32/4/32/4/32  the selected slot's fields.
- trace_last  out  1  the current beat is the final beat of its instruction.
- overflow  out  1  sticky; set when a retirement was dropped.
- drop_cnt  out  16  number of dropped retirements; saturates at 0xFFFF.
- overflow_clr  in  1  synchronous clear of `overflow` and `drop_cnt`.

## Operation
- Push: when rvfi_valid & trace_en & !full, the entire RVFI bundle is written at the write pointer.
  - A push is decided on the pre-edge `full` only. A pop in the same cycle does not free a slot for that cycle's push.
- Drop: when rvfi_valid & trace_en & full, nothing is written, `overflow` is set and `drop_cnt` is incremented (saturating).
  - If overflow_clr and a drop occur in the same cycle, the drop wins: overflow=1, drop_cnt=1.
  - overflow_clr on its own forces overflow=0 and drop_cnt=0.
- Slot activity: slot i is active when rmask[i]|wmask[i] != 0. Beats are emitted for active slots in ascending index order; inactive slots are skipped.
- No active slot: exactly one beat is emitted with memidx=0, all mask, address and data outputs 0, and trace_last=1.
- FSM has two states: IDLE and EMIT.
  - IDLE -> EMIT when the FIFO is not empty. On entry, `cur` is loaded with the lowest active slot index, or 0 if no slot is active.
  - EMIT with trace_ready=1 and trace_last=0: `cur` advances to the next active index above `cur`.
  - EMIT with trace_ready=1 and trace_last=1: the FIFO entry is popped. If FIFO count after the pop is greater than 0, the FSM stays in EMIT and reloads `cur` from the new head entry. Otherwise it returns to IDLE.
- trace_last=1 when no active slot exists above `cur`, or when the instruction has no active slot at all.
- Pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits. full = (count==DEPTH); empty = (count==0).

## Timing
- Reset values: trace_valid=0, all trace_* data outputs 0, trace_last=0, overflow=0, drop_cnt=0, FIFO empty, FSM in IDLE.
- Latency: a push at edge N makes trace_valid=1 after edge N+1, because the IDLE->EMIT transition is registered. Minimum spacing is therefore 2 cycles from rvfi_valid to the first beat.
- Throughput in steady EMIT: one beat per cycle while trace_ready=1. There is no bubble between instructions.
- AXI-style handshake:
  - Once trace_valid=1, the FSM holds it and all trace_* outputs stable until trace_ready=1.
  - trace_valid does not depend combinationally on trace_ready.
- Outputs are driven from the registered `cur` and the FIFO head, through a combinational slot mux.
- Assertion of rst at any time, including mid-instruction, returns everything to reset values immediately. Partially emitted instructions are discarded.

## Test plan
- Single instruction, no memory op: push pc=0x00000080, rd=x5, wdata=0x11, masks all 0, trace_ready=1 -> one beat 2 cycles later with memidx=0, masks=0, last=1; FSM returns to IDLE.
- Two-slot store/load (NMEM=2): slot0 wmask=0xF, addr=0x1000, wdata=0xA5A5A5A5; slot1 rmask=0x3, addr=0x2004, rdata=0x0000BEEF; trace_ready=1 -> beat memidx=0 last=0, then beat memidx=1 last=1, on consecutive cycles.
- Sparse slots: slot0 masks 0, slot1 rmask=0xF -> exactly one beat with memidx=1 and last=1.
- Back-pressure: hold trace_ready=0 for 10 cycles with one pending beat -> trace_valid and all data stay stable; the beat is accepted on the first cycle trace_ready=1.
- Overflow (DEPTH=4): trace_ready=0, 6 consecutive retirements -> 4 stored, overflow=1, drop_cnt=2.
  - Then trace_ready=1 -> exactly 4 instructions are emitted, with PCs in order.
  - overflow_clr together with a drop in the same cycle -> overflow=1, drop_cnt=1.
- Reset mid-EMIT: assert rst after the first of two beats -> trace_valid=0 that cycle, count=0; a new push after rst is released emits normally.

Source files
------------

// File: rtl/cv32e40x_rvfi_trace_sequencer_if.sv
// Port bundles for the RVFI trace sequencer: the retirement bundle coming in from the core
// and the beat stream going out to the trace sink.

interface cv32e40x_rvfi_if #(parameter int NMEM = 2) ();
   logic                 rvfi_valid;
   logic [31:0]          rvfi_pc_rdata;
   logic [4:0]           rvfi_rd_addr;
   logic [31:0]          rvfi_rd_wdata;
   logic [32*NMEM-1:0]   rvfi_mem_addr;
   logic [4*NMEM-1:0]    rvfi_mem_rmask;
   logic [4*NMEM-1:0]    rvfi_mem_wmask;
   logic [32*NMEM-1:0]   rvfi_mem_rdata;
   logic [32*NMEM-1:0]   rvfi_mem_wdata;

   modport master (output rvfi_valid, rvfi_pc_rdata, rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr,
                          rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata);
   modport slave  (input  rvfi_valid, rvfi_pc_rdata, rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr,
                          rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata);
endinterface

// Handshake: a beat transfers on a clock edge where trace_valid & trace_ready. Once raised,
// trace_valid and every data field hold until that transfer, and trace_valid never looks at trace_ready.
interface cv32e40x_trace_if #(parameter int NMEM = 2) ();
   localparam int MW = (NMEM > 1) ? $clog2(NMEM) : 1;

   logic           trace_valid;
   logic           trace_ready;
   logic [31:0]    trace_pc;
   logic [4:0]     trace_rd_addr;
   logic [31:0]    trace_rd_wdata;
   logic [MW-1:0]  trace_memidx;
   logic [31:0]    trace_mem_addr;
   logic [3:0]     trace_mem_rmask;
   logic [31:0]    trace_mem_rdata;
   logic [3:0]     trace_mem_wmask;
   logic [31:0]    trace_mem_wdata;
   logic           trace_last;

   modport master (output trace_valid, trace_pc, trace_rd_addr, trace_rd_wdata, trace_memidx,
                          trace_mem_addr, trace_mem_rmask, trace_mem_rdata, trace_mem_wmask,
                          trace_mem_wdata, trace_last,
                   input  trace_ready);
   modport slave  (input  trace_valid, trace_pc, trace_rd_addr, trace_rd_wdata, trace_memidx,
                          trace_mem_addr, trace_mem_rmask, trace_mem_rdata, trace_mem_wmask,
                          trace_mem_wdata, trace_last,
                   output trace_ready);
endinterface

// File: rtl/cv32e40x_rvfi_trace_sequencer.sv
// Buffers retired instructions in a FIFO and unrolls each into one trace beat per active
// memory slot (or a single beat when no slot is active).

module cv32e40x_rvfi_trace_sequencer #(
   parameter int NMEM  = 2,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     trace_en,
   cv32e40x_rvfi_if.slave           rvfi,
   cv32e40x_trace_if.master         trace,
   output logic                     overflow,
   output logic [15:0]              drop_cnt,
   input  logic                     overflow_clr,
   output logic                     dbg_state,
   output logic [$clog2(DEPTH):0]   dbg_count
);
   localparam int MW = (NMEM > 1) ? $clog2(NMEM) : 1;
   localparam int PW = $clog2(DEPTH);

   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   function automatic logic [NMEM-1:0] slot_act(input logic [4*NMEM-1:0] rm,
                                                input logic [4*NMEM-1:0] wm);
      logic [NMEM-1:0] a;
      for (int i = 0; i < NMEM; i++) a[i] = (|rm[4*i +: 4]) | (|wm[4*i +: 4]);
      return a;
   endfunction

   function automatic logic [MW-1:0] lowest(input logic [NMEM-1:0] v);
      logic [MW-1:0] r;
      r = '0;
      for (int i = NMEM - 1; i >= 0; i--) if (v[i]) r = MW'(i);
      return r;
   endfunction

   logic [31:0]        pc_q    [DEPTH];
   logic [4:0]         rd_q    [DEPTH];
   logic [31:0]        wd_q    [DEPTH];
   logic [32*NMEM-1:0] maddr_q [DEPTH];
   logic [4*NMEM-1:0]  rmask_q [DEPTH];
   logic [4*NMEM-1:0]  wmask_q [DEPTH];
   logic [32*NMEM-1:0] rdata_q [DEPTH];
   logic [32*NMEM-1:0] wdata_q [DEPTH];

   state_t          state;
   logic [PW-1:0]   wr_ptr, rd_ptr, nxt_ptr;
   logic [PW:0]     count, count_next;
   logic [MW-1:0]   cur, nxt_idx;
   logic [NMEM-1:0] head_act, next_act, in_act, reload_act;
   logic            more, full, empty, capture, push, drop, pop, emit, sel;

   assign full       = (count == (PW+1)'(DEPTH));
   assign empty      = (count == '0);
   assign capture    = rvfi.rvfi_valid & trace_en;
   assign push       = capture & ~full;
   assign drop       = capture & full;
   assign emit       = (state == EMIT);
   assign pop        = emit & trace.trace_ready & ~more;
   assign nxt_ptr    = rd_ptr + PW'(1);
   assign count_next = count + (PW+1)'(push) - (PW+1)'(pop);

   assign head_act   = slot_act(rmask_q[rd_ptr], wmask_q[rd_ptr]);
   assign next_act   = slot_act(rmask_q[nxt_ptr], wmask_q[nxt_ptr]);
   assign in_act     = slot_act(rvfi.rvfi_mem_rmask, rvfi.rvfi_mem_wmask);
   // With a single entry left, the next head is the one being pushed this very cycle.
   assign reload_act = (count > (PW+1)'(1)) ? next_act : in_act;

   always_comb begin
      nxt_idx = '0;
      more    = 1'b0;
      for (int i = NMEM - 1; i >= 0; i--) begin
         if (head_act[i] && (i > int'(cur))) begin
            nxt_idx = MW'(i);
            more    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_q[wr_ptr]    <= rvfi.rvfi_pc_rdata;
         rd_q[wr_ptr]    <= rvfi.rvfi_rd_addr;
         wd_q[wr_ptr]    <= rvfi.rvfi_rd_wdata;
         maddr_q[wr_ptr] <= rvfi.rvfi_mem_addr;
         rmask_q[wr_ptr] <= rvfi.rvfi_mem_rmask;
         wmask_q[wr_ptr] <= rvfi.rvfi_mem_wmask;
         rdata_q[wr_ptr] <= rvfi.rvfi_mem_rdata;
         wdata_q[wr_ptr] <= rvfi.rvfi_mem_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cur      <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= nxt_ptr;
         count <= count_next;

         case (state)
            IDLE: begin
               if (!empty) begin
                  state <= EMIT;
                  cur   <= lowest(head_act);
               end
            end
            EMIT: begin
               if (trace.trace_ready) begin
                  if (more) begin
                     cur <= nxt_idx;
                  end else if (count_next != '0) begin
                     cur <= lowest(reload_act);
                  end else begin
                     state <= IDLE;
                     cur   <= '0;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // A drop in the same cycle as a clear restarts the count at one.
         if (drop) begin
            overflow <= 1'b1;
            if (overflow_clr)              drop_cnt <= 16'd1;
            else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         end else if (overflow_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
         end
      end
   end

   // Slot fields are zeroed when the selected slot is inactive (the no-memory-access beat).
   assign sel                   = emit & head_act[cur];
   assign trace.trace_valid     = emit;
   assign trace.trace_last      = emit & ~more;
   assign trace.trace_memidx    = cur;
   assign trace.trace_pc        = emit ? pc_q[rd_ptr] : '0;
   assign trace.trace_rd_addr   = emit ? rd_q[rd_ptr] : '0;
   assign trace.trace_rd_wdata  = emit ? wd_q[rd_ptr] : '0;
   assign trace.trace_mem_addr  = sel ? maddr_q[rd_ptr][32*int'(cur) +: 32] : '0;
   assign trace.trace_mem_rdata = sel ? rdata_q[rd_ptr][32*int'(cur) +: 32] : '0;
   assign trace.trace_mem_wdata = sel ? wdata_q[rd_ptr][32*int'(cur) +: 32] : '0;
   assign trace.trace_mem_rmask = sel ? rmask_q[rd_ptr][4*int'(cur) +: 4] : '0;
   assign trace.trace_mem_wmask = sel ? wmask_q[rd_ptr][4*int'(cur) +: 4] : '0;

   assign dbg_state = state;
   assign dbg_count = count;
endmodule

// File: tb/tb_cv32e40x_rvfi_trace_sequencer.sv
// Directed bench for the RVFI trace sequencer with NMEM=2, DEPTH=4.

module tb_cv32e40x_rvfi_trace_sequencer;
   logic        clk;
   logic        rst;
   logic        trace_en;
   logic        overflow;
   logic [15:0] drop_cnt;
   logic        overflow_clr;
   logic        dbg_state;
   logic [2:0]  dbg_count;

   int total;
   int bad;
   logic [31:0] exp_q[$];

   cv32e40x_rvfi_if  #(.NMEM(2)) rvfi_bus ();
   cv32e40x_trace_if #(.NMEM(2)) trace_bus ();

   cv32e40x_rvfi_trace_sequencer #(.NMEM(2), .DEPTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .trace_en     (trace_en),
      .rvfi         (rvfi_bus),
      .trace        (trace_bus),
      .overflow     (overflow),
      .drop_cnt     (drop_cnt),
      .overflow_clr (overflow_clr),
      .dbg_state    (dbg_state),
      .dbg_count    (dbg_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_rvfi(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] wd,
                             input logic [63:0] addr, input logic [7:0] rmask, input logic [7:0] wmask,
                             input logic [63:0] rdata, input logic [63:0] wdata);
      rvfi_bus.rvfi_valid     = 1'b1;
      rvfi_bus.rvfi_pc_rdata  = pc;
      rvfi_bus.rvfi_rd_addr   = rd;
      rvfi_bus.rvfi_rd_wdata  = wd;
      rvfi_bus.rvfi_mem_addr  = addr;
      rvfi_bus.rvfi_mem_rmask = rmask;
      rvfi_bus.rvfi_mem_wmask = wmask;
      rvfi_bus.rvfi_mem_rdata = rdata;
      rvfi_bus.rvfi_mem_wdata = wdata;
   endtask

   task automatic push_one(input logic [31:0] pc, input logic [63:0] addr, input logic [7:0] rmask,
                           input logic [7:0] wmask, input logic [63:0] rdata, input logic [63:0] wdata);
      drive_rvfi(pc, 5'd5, 32'h11, addr, rmask, wmask, rdata, wdata);
      step();
      rvfi_bus.rvfi_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      total++; if (trace_bus.trace_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", trace_bus.trace_valid); end
      total++; if (trace_bus.trace_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", trace_bus.trace_pc); end
      total++; if (trace_bus.trace_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", trace_bus.trace_last); end
      total++; if (trace_bus.trace_memidx !== 1'b0) begin bad++; $display("FAIL reset_memidx got=%h exp=0", trace_bus.trace_memidx); end
      total++; if (overflow !== 1'b0 || drop_cnt !== 16'h0) begin bad++; $display("FAIL reset_ovf got=%b/%h exp=0/0", overflow, drop_cnt); end
      total++; if (dbg_count !== 3'd0 || dbg_state !== 1'b0) begin bad++; $display("FAIL reset_fifo got=%0d/%b exp=0/0", dbg_count, dbg_state); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_trace_en();
      trace_en = 1'b0;
      push_one(32'h500, 64'h0, 8'h0, 8'h0, 64'h0, 64'h0);
      total++; if (dbg_count !== 3'd0 || overflow !== 1'b0) begin bad++; $display("FAIL en_ignore got=%0d/%b exp=0/0", dbg_count, overflow); end
      step();
      total++; if (trace_bus.trace_valid !== 1'b0) begin bad++; $display("FAIL en_valid got=%b exp=0", trace_bus.trace_valid); end
      trace_en = 1'b1;
   endtask

   task automatic test_no_mem();
      trace_bus.trace_ready = 1'b1;
      push_one(32'h80, {32'h0, 32'hDEAD0000}, 8'h0, 8'h0, 64'h1234, 64'h5678);
      total++; if (trace_bus.trace_valid !== 1'b0) begin bad++; $display("FAIL nomem_latency got=%b exp=0", trace_bus.trace_valid); end
      step();
      total++; if (trace_bus.trace_valid !== 1'b1 || trace_bus.trace_pc !== 32'h80) begin bad++; $display("FAIL nomem_beat got=%b/%h exp=1/00000080", trace_bus.trace_valid, trace_bus.trace_pc); end
      total++; if (trace_bus.trace_rd_addr !== 5'd5 || trace_bus.trace_rd_wdata !== 32'h11) begin bad++; $display("FAIL nomem_rd got=%h/%h exp=05/00000011", trace_bus.trace_rd_addr, trace_bus.trace_rd_wdata); end
      total++; if (trace_bus.trace_memidx !== 1'b0 || trace_bus.trace_last !== 1'b1) begin bad++; $display("FAIL nomem_idx_last got=%h/%b exp=0/1", trace_bus.trace_memidx, trace_bus.trace_last); end
      total++; if (trace_bus.trace_mem_rmask !== 4'h0 || trace_bus.trace_mem_wmask !== 4'h0 || trace_bus.trace_mem_addr !== 32'h0 || trace_bus.trace_mem_rdata !== 32'h0 || trace_bus.trace_mem_wdata !== 32'h0) begin
         bad++; $display("FAIL nomem_zero got=%h/%h/%h/%h/%h exp=all 0", trace_bus.trace_mem_rmask, trace_bus.trace_mem_wmask, trace_bus.trace_mem_addr, trace_bus.trace_mem_rdata, trace_bus.trace_mem_wdata);
      end
      step();
      total++; if (trace_bus.trace_valid !== 1'b0 || dbg_state !== 1'b0) begin bad++; $display("FAIL nomem_idle got=%b/%b exp=0/0", trace_bus.trace_valid, dbg_state); end
   endtask

   task automatic test_two_slot();
      trace_bus.trace_ready = 1'b1;
      push_one(32'h90, {32'h2004, 32'h1000}, 8'h30, 8'h0F, {32'h0000BEEF, 32'h0}, {32'h0, 32'hA5A5A5A5});
      step();
      total++; if (trace_bus.trace_valid !== 1'b1 || trace_bus.trace_memidx !== 1'b0 || trace_bus.trace_last !== 1'b0) begin bad++; $display("FAIL two_beat0 got=%b/%h/%b exp=1/0/0", trace_bus.trace_valid, trace_bus.trace_memidx, trace_bus.trace_last); end
      total++; if (trace_bus.trace_mem_addr !== 32'h1000 || trace_bus.trace_mem_wmask !== 4'hF || trace_bus.trace_mem_wdata !== 32'hA5A5A5A5 || trace_bus.trace_mem_rmask !== 4'h0) begin
         bad++; $display("FAIL two_data0 got=%h/%h/%h/%h exp=00001000/f/a5a5a5a5/0", trace_bus.trace_mem_addr, trace_bus.trace_mem_wmask, trace_bus.trace_mem_wdata, trace_bus.trace_mem_rmask);
      end
      step();
      total++; if (trace_bus.trace_valid !== 1'b1 || trace_bus.trace_memidx !== 1'b1 || trace_bus.trace_last !== 1'b1) begin bad++; $display("FAIL two_beat1 got=%b/%h/%b exp=1/1/1", trace_bus.trace_valid, trace_bus.trace_memidx, trace_bus.trace_last); end
      total++; if (trace_bus.trace_mem_addr !== 32'h2004 || trace_bus.trace_mem_rmask !== 4'h3 || trace_bus.trace_mem_rdata !== 32'h0000BEEF || trace_bus.trace_mem_wmask !== 4'h0) begin
         bad++; $display("FAIL two_data1 got=%h/%h/%h/%h exp=00002004/3/0000beef/0", trace_bus.trace_mem_addr, trace_bus.trace_mem_rmask, trace_bus.trace_mem_rdata, trace_bus.trace_mem_wmask);
      end
      step();
      total++; if (trace_bus.trace_valid !== 1'b0) begin bad++; $display("FAIL two_end got=%b exp=0", trace_bus.trace_valid); end
   endtask

   task automatic test_sparse();
      trace_bus.trace_ready = 1'b1;
      push_one(32'hA0, {32'h3000, 32'h0}, 8'hF0, 8'h00, {32'h0000CAFE, 32'h0}, 64'h0);
      step();
      total++; if (trace_bus.trace_valid !== 1'b1 || trace_bus.trace_memidx !== 1'b1 || trace_bus.trace_last !== 1'b1) begin bad++; $display("FAIL sparse_beat got=%b/%h/%b exp=1/1/1", trace_bus.trace_valid, trace_bus.trace_memidx, trace_bus.trace_last); end
      total++; if (trace_bus.trace_mem_addr !== 32'h3000 || trace_bus.trace_mem_rmask !== 4'hF || trace_bus.trace_mem_rdata !== 32'h0000CAFE) begin bad++; $display("FAIL sparse_data got=%h/%h/%h exp=00003000/f/0000cafe", trace_bus.trace_mem_addr, trace_bus.trace_mem_rmask, trace_bus.trace_mem_rdata); end
      step();
      total++; if (trace_bus.trace_valid !== 1'b0) begin bad++; $display("FAIL sparse_end got=%b exp=0", trace_bus.trace_valid); end
   endtask

   task automatic test_back_pressure();
      trace_bus.trace_ready = 1'b0;
      push_one(32'h200, {32'h0, 32'h5000}, 8'h00, 8'h0F, 64'h0, {32'h0, 32'h00000077});
      step();
      for (int i = 0; i < 10; i++) begin
         total++;
         if (trace_bus.trace_valid !== 1'b1 || trace_bus.trace_pc !== 32'h200 || trace_bus.trace_mem_addr !== 32'h5000 ||
             trace_bus.trace_mem_wdata !== 32'h77 || trace_bus.trace_mem_wmask !== 4'hF || trace_bus.trace_last !== 1'b1) begin
            bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%h/%h exp=1/00000200/00005000/00000077", i, trace_bus.trace_valid, trace_bus.trace_pc, trace_bus.trace_mem_addr, trace_bus.trace_mem_wdata);
         end
         step();
      end
      trace_bus.trace_ready = 1'b1;
      total++; if (trace_bus.trace_valid !== 1'b1) begin bad++; $display("FAIL bp_pre_accept got=%b exp=1", trace_bus.trace_valid); end
      step();
      total++; if (trace_bus.trace_valid !== 1'b0 || dbg_count !== 3'd0) begin bad++; $display("FAIL bp_accept got=%b/%0d exp=0/0", trace_bus.trace_valid, dbg_count); end
   endtask

   task automatic test_overflow();
      logic [31:0] exp_pc;
      trace_bus.trace_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         drive_rvfi(32'h100 + 32'(4 * k), 5'd1, 32'h0, 64'h0, 8'h0, 8'h0, 64'h0, 64'h0);
         if (k < 4) exp_q.push_back(32'h100 + 32'(4 * k));
         step();
      end
      rvfi_bus.rvfi_valid = 1'b0;
      total++; if (dbg_count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", dbg_count); end
      total++; if (overflow !== 1'b1 || drop_cnt !== 16'd2) begin bad++; $display("FAIL ovf_flag got=%b/%0d exp=1/2", overflow, drop_cnt); end
      trace_bus.trace_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_pc = exp_q.pop_front();
         total++; if (trace_bus.trace_valid !== 1'b1 || trace_bus.trace_pc !== exp_pc) begin bad++; $display("FAIL ovf_drain k=%0d got=%b/%h exp=1/%h", k, trace_bus.trace_valid, trace_bus.trace_pc, exp_pc); end
         step();
      end
      total++; if (trace_bus.trace_valid !== 1'b0 || dbg_count !== 3'd0) begin bad++; $display("FAIL ovf_empty got=%b/%0d exp=0/0", trace_bus.trace_valid, dbg_count); end

      trace_bus.trace_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive_rvfi(32'h300 + 32'(4 * k), 5'd2, 32'h0, 64'h0, 8'h0, 8'h0, 64'h0, 64'h0);
         exp_q.push_back(32'h300 + 32'(4 * k));
         step();
      end
      drive_rvfi(32'h3FF, 5'd2, 32'h0, 64'h0, 8'h0, 8'h0, 64'h0, 64'h0);
      overflow_clr = 1'b1;
      step();
      rvfi_bus.rvfi_valid = 1'b0;
      overflow_clr = 1'b0;
      total++; if (overflow !== 1'b1 || drop_cnt !== 16'd1) begin bad++; $display("FAIL clr_and_drop got=%b/%0d exp=1/1", overflow, drop_cnt); end
      overflow_clr = 1'b1;
      step();
      overflow_clr = 1'b0;
      total++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin bad++; $display("FAIL clr_only got=%b/%0d exp=0/0", overflow, drop_cnt); end
      trace_bus.trace_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_pc = exp_q.pop_front();
         total++; if (trace_bus.trace_valid !== 1'b1 || trace_bus.trace_pc !== exp_pc) begin bad++; $display("FAIL clr_drain k=%0d got=%b/%h exp=1/%h", k, trace_bus.trace_valid, trace_bus.trace_pc, exp_pc); end
         step();
      end
      total++; if (trace_bus.trace_valid !== 1'b0 || dbg_count !== 3'd0) begin bad++; $display("FAIL clr_empty got=%b/%0d exp=0/0", trace_bus.trace_valid, dbg_count); end
   endtask

   task automatic test_reset_mid();
      trace_bus.trace_ready = 1'b1;
      push_one(32'hC0, {32'h2004, 32'h1000}, 8'h30, 8'h0F, 64'h0, 64'h0);
      step();
      total++; if (trace_bus.trace_memidx !== 1'b0 || trace_bus.trace_valid !== 1'b1) begin bad++; $display("FAIL mid_beat0 got=%h/%b exp=0/1", trace_bus.trace_memidx, trace_bus.trace_valid); end
      step();
      total++; if (trace_bus.trace_memidx !== 1'b1 || trace_bus.trace_valid !== 1'b1) begin bad++; $display("FAIL mid_beat1 got=%h/%b exp=1/1", trace_bus.trace_memidx, trace_bus.trace_valid); end
      rst = 1'b1;
      #1;
      total++; if (trace_bus.trace_valid !== 1'b0 || dbg_count !== 3'd0 || dbg_state !== 1'b0) begin bad++; $display("FAIL mid_rst got=%b/%0d/%b exp=0/0/0", trace_bus.trace_valid, dbg_count, dbg_state); end
      total++; if (trace_bus.trace_pc !== 32'h0 || trace_bus.trace_memidx !== 1'b0) begin bad++; $display("FAIL mid_rst_data got=%h/%h exp=0/0", trace_bus.trace_pc, trace_bus.trace_memidx); end
      rst = 1'b0;
      step();
      push_one(32'h400, 64'h0, 8'h0, 8'h0, 64'h0, 64'h0);
      step();
      total++; if (trace_bus.trace_valid !== 1'b1 || trace_bus.trace_pc !== 32'h400 || trace_bus.trace_last !== 1'b1) begin bad++; $display("FAIL mid_after got=%b/%h/%b exp=1/00000400/1", trace_bus.trace_valid, trace_bus.trace_pc, trace_bus.trace_last); end
      step();
      total++; if (trace_bus.trace_valid !== 1'b0) begin bad++; $display("FAIL mid_after_end got=%b exp=0", trace_bus.trace_valid); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1;
      trace_en = 1'b1;
      overflow_clr = 1'b0;
      trace_bus.trace_ready = 1'b0;
      drive_rvfi(32'h0, 5'd0, 32'h0, 64'h0, 8'h0, 8'h0, 64'h0, 64'h0);
      rvfi_bus.rvfi_valid = 1'b0;

      test_reset();
      test_trace_en();
      test_no_mem();
      test_two_slot();
      test_sparse();
      test_back_pressure();
      test_overflow();
      test_reset_mid();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
